// File: rtl/block_dispatcher.sv
// block_dispatcher: takes blocks from the IFE serial and parallel channels into one
// shared FIFO. It then issues them in FIFO order to idle nebula cores, which are
// scanned round-robin. Several cores can be issued to in the same cycle.
//
// Handshake: a transfer happens on a rising edge when the source's valid is high
// and its ready is high at the same time. Ready depends combinationally on the
// registered FIFO count and on the valids, and never on a transfer in the same
// cycle. A parallel group is one transfer: either every valid lane is taken, or
// none is.
module block_dispatcher #(
  parameter int NUM_CORES    = 3,
  parameter int NUM_LANES    = 2,
  parameter int FIFO_DEPTH   = 8,
  parameter int WORDS        = 4,
  parameter int DATA_W       = 32,
  parameter int ID_W         = 8,
  parameter int SERIAL_FIRST = 1,
  localparam int BW          = WORDS * DATA_W,
  localparam int CW          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ser_valid,
  output logic                      ser_ready,
  input  logic [ID_W-1:0]           ser_id,
  input  logic [BW-1:0]             ser_data,
  input  logic [NUM_LANES-1:0]      par_valid,
  output logic                      par_ready,
  input  logic [ID_W-1:0]           par_id,
  input  logic [NUM_LANES*BW-1:0]   par_data,
  input  logic [NUM_CORES-1:0]      core_busy,
  output logic [NUM_CORES-1:0]      core_valid,
  output logic [NUM_CORES*BW-1:0]   core_data,
  output logic [NUM_CORES*ID_W-1:0] core_id,
  output logic [CW-1:0]             fifo_count,
  output logic                      idle
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CIW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [ID_W-1:0]      mem_id   [FIFO_DEPTH];
  logic [BW-1:0]        mem_data [FIFO_DEPTH];
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [CW-1:0]        count;
  logic [CIW-1:0]       rr_ptr;

  logic [CW-1:0]        free;
  logic [CW-1:0]        pc;
  logic [CW-1:0]        enq_n;
  logic [CW-1:0]        n_disp;
  logic [PW-1:0]        lane_off [NUM_LANES];
  logic                 par_fit;
  logic                 ser_acc;
  logic                 par_acc;
  logic [NUM_CORES-1:0] avail;
  logic [NUM_CORES-1:0] grant;
  logic [PW-1:0]        grant_slot [NUM_CORES];
  logic [CIW-1:0]       last_core;
  logic [CIW-1:0]       rr_next;

  assign fifo_count = count;
  assign free       = CW'(FIFO_DEPTH) - count;

  // Lane slot offsets: each valid lane goes into the next free slot after the
  // lower valid lanes, so zero lanes leave no holes. pc ends as popcount.
  always_comb begin
    pc = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_off[l] = PW'(pc);
      if (par_valid[l]) pc = pc + CW'(1);
    end
  end

  assign par_fit = (pc != '0) && (free >= pc);

  generate
    if (SERIAL_FIRST != 0) begin : g_ser_first
      assign ser_ready = (free != '0);
      assign par_ready = par_fit && !ser_valid;
    end else begin : g_par_first
      assign par_ready = par_fit;
      assign ser_ready = (free != '0) && !par_fit;
    end
  endgenerate

  assign ser_acc = ser_valid && ser_ready;
  assign par_acc = par_ready;
  assign enq_n   = ser_acc ? CW'(1) : (par_acc ? pc : '0);

  // A core pulsed last cycle has not raised busy yet, so it is not available.
  assign avail = ~core_busy & ~core_valid;

  // Round-robin scan from rr_ptr: the k-th available core gets the FIFO entry
  // head+k. Only entries present at the start of the cycle are used.
  always_comb begin : dispatch_scan
    int idx;
    idx       = 0;
    grant     = '0;
    n_disp    = '0;
    last_core = rr_ptr;
    for (int c = 0; c < NUM_CORES; c++) grant_slot[c] = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (avail[idx] && (n_disp < count)) begin
        grant[idx]      = 1'b1;
        grant_slot[idx] = head + PW'(n_disp);
        last_core       = CIW'(idx);
        n_disp          = n_disp + CW'(1);
      end
    end
  end

  // Next scan start: one past the last granted core. It holds when nothing issues.
  always_comb begin
    rr_next = rr_ptr;
    if (n_disp != '0) begin
      if (int'(last_core) == NUM_CORES - 1) rr_next = '0;
      else                                  rr_next = last_core + CIW'(1);
    end
  end

  // FIFO payload storage. It is not reset because the pointers and count decide
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (ser_acc) begin
      mem_id[tail]   <= ser_id;
      mem_data[tail] <= ser_data;
    end else if (par_acc) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (par_valid[l]) begin
          mem_id[tail + lane_off[l]]   <= par_id;
          mem_data[tail + lane_off[l]] <= par_data[l*BW +: BW];
        end
      end
    end
  end

  // Pointers, count, round-robin pointer and the registered core outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      rr_ptr     <= '0;
      core_valid <= '0;
      core_data  <= '0;
      core_id    <= '0;
    end else begin
      head       <= head + PW'(n_disp);
      tail       <= tail + PW'(enq_n);
      count      <= count + enq_n - n_disp;
      rr_ptr     <= rr_next;
      core_valid <= grant;
      for (int c = 0; c < NUM_CORES; c++) begin
        if (grant[c]) begin
          core_data[c*BW +: BW]     <= mem_data[grant_slot[c]];
          core_id[c*ID_W +: ID_W]   <= mem_id[grant_slot[c]];
        end
      end
    end
  end

  assign idle = (count == '0) && (core_valid == '0) && (core_busy == '0);

endmodule
